// File: rtl/wash_pkg.sv
`default_nettype none
// ============================================================================
// Module : wash_pkg
// Brief  : Shared state encodings and program codes for the programmable
//          washing-machine controller.
// Rev    : 1.0  initial release
// ============================================================================
package wash_pkg;

  // Controller states; the encoding is visible on state_o.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_t;

  // Program selector codes, latched when a coin is accepted.
  localparam logic [1:0] PROG_NORMAL = 2'b00;
  localparam logic [1:0] PROG_DOUBLE = 2'b01;
  localparam logic [1:0] PROG_QUICK  = 2'b10;
  localparam logic [1:0] PROG_XRINSE = 2'b11;

endpackage
`default_nettype wire

// File: rtl/wash_sec_tick.sv
`default_nettype none
// ============================================================================
// Module : wash_sec_tick
// Brief  : One-second prescaler. Counts enabled cycles and pulses tick on the
//          last cycle of each CLK_HZ-cycle period. clr restarts the period.
// Rev    : 1.0  initial release
// ============================================================================
module wash_sec_tick #(
  parameter int CLK_HZ = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int c_cw = $clog2(CLK_HZ);
  localparam logic [c_cw-1:0] c_last = c_cw'(CLK_HZ - 1);

  logic [c_cw-1:0] r_cnt;

  // Tick only on an enabled cycle so a frozen machine never advances time.
  assign tick = en && (r_cnt == c_last);

  // Prescaler count: cleared on reset or phase entry, holds when disabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wash_ctrl_prog.sv
`default_nettype none
// ============================================================================
// Module : wash_ctrl_prog
// Brief  : Coin-operated washing-machine controller with four programs,
//          door interlock, spin pause and per-phase actuator outputs.
// Rev    : 1.0  initial release
// ============================================================================
module wash_ctrl_prog
  import wash_pkg::*;
#(
  parameter int CLK_HZ  = 1_000_000,
  parameter int FILL_S  = 60,
  parameter int WASH_S  = 300,
  parameter int RINSE_S = 120,
  parameter int SPIN_S  = 60,
  parameter int TMR_W   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic [1:0] prog,
  input  logic       door_open,
  input  logic       timer_pause,
  output logic       wash_done,
  output logic       done_pulse,
  output logic       valve_on,
  output logic       agitate_on,
  output logic       spin_on,
  output logic [2:0] state_o
);

  // Timer load values are duration-1 so each phase lasts duration ticks.
  localparam int c_quick_s = ((WASH_S >> 1) < 1) ? 1 : (WASH_S >> 1);
  localparam logic [TMR_W-1:0] c_fill_ld  = TMR_W'(FILL_S - 1);
  localparam logic [TMR_W-1:0] c_wash_ld  = TMR_W'(WASH_S - 1);
  localparam logic [TMR_W-1:0] c_quick_ld = TMR_W'(c_quick_s - 1);
  localparam logic [TMR_W-1:0] c_rinse_ld = TMR_W'(RINSE_S - 1);
  localparam logic [TMR_W-1:0] c_spin_ld  = TMR_W'(SPIN_S - 1);

  state_t           r_state, w_state_n;
  logic [TMR_W-1:0] r_timer, w_timer_n;
  logic             r_pass, w_pass_n;
  logic             r_rinse, w_rinse_n;
  logic [1:0]       r_prog, w_prog_n;
  logic             r_door, r_pause;
  logic             r_done_pulse, w_done_n;
  logic             w_phase_start;
  logic             w_frozen;
  logic             w_tick;
  logic [TMR_W-1:0] w_wash_ld;

  // Door and pause are registered before use so no input reaches an output
  // combinationally; a freeze therefore takes effect one cycle after the pin.
  assign w_frozen  = r_door || ((r_state == ST_SPIN) && r_pause);
  assign w_wash_ld = (r_prog == PROG_QUICK) ? c_quick_ld : c_wash_ld;

  wash_sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_phase_start),
    .en   ((r_state != ST_IDLE) && !w_frozen),
    .tick (w_tick)
  );

  // Next-state, phase timer and program-sequence counters.
  always_comb begin
    w_state_n     = r_state;
    w_timer_n     = r_timer;
    w_pass_n      = r_pass;
    w_rinse_n     = r_rinse;
    w_prog_n      = r_prog;
    w_phase_start = 1'b0;
    w_done_n      = 1'b0;
    if (r_state == ST_IDLE) begin
      if (coin_in && !door_open) begin
        w_state_n     = ST_FILL;
        w_prog_n      = prog;
        w_pass_n      = 1'b0;
        w_rinse_n     = 1'b0;
        w_timer_n     = c_fill_ld;
        w_phase_start = 1'b1;
      end
    end else if (w_tick) begin
      if (r_timer != '0) begin
        w_timer_n = r_timer - TMR_W'(1);
      end else begin
        w_phase_start = 1'b1;
        case (r_state)
          ST_FILL: begin
            w_state_n = ST_WASH;
            w_timer_n = w_wash_ld;
          end
          ST_WASH: begin
            w_state_n = ST_RINSE;
            w_timer_n = c_rinse_ld;
          end
          ST_RINSE: begin
            if ((r_prog == PROG_DOUBLE) && !r_pass) begin
              w_state_n = ST_FILL;
              w_pass_n  = 1'b1;
              w_timer_n = c_fill_ld;
            end else if ((r_prog == PROG_XRINSE) && !r_rinse) begin
              w_state_n = ST_RINSE;
              w_rinse_n = 1'b1;
              w_timer_n = c_rinse_ld;
            end else begin
              w_state_n = ST_SPIN;
              w_timer_n = c_spin_ld;
            end
          end
          ST_SPIN: begin
            w_state_n     = ST_IDLE;
            w_timer_n     = '0;
            w_done_n      = 1'b1;
            w_phase_start = 1'b0;
          end
          default: begin
            w_state_n     = ST_IDLE;
            w_timer_n     = '0;
            w_phase_start = 1'b0;
          end
        endcase
      end
    end
  end

  // State and datapath registers; reset returns to IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_pass       <= 1'b0;
      r_rinse      <= 1'b0;
      r_prog       <= PROG_NORMAL;
      r_door       <= 1'b0;
      r_pause      <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_timer      <= w_timer_n;
      r_pass       <= w_pass_n;
      r_rinse      <= w_rinse_n;
      r_prog       <= w_prog_n;
      r_door       <= door_open;
      r_pause      <= timer_pause;
      r_done_pulse <= w_done_n;
    end
  end

  assign wash_done  = (r_state == ST_IDLE);
  assign done_pulse = r_done_pulse;
  assign valve_on   = (r_state == ST_FILL) && !w_frozen;
  assign agitate_on = ((r_state == ST_WASH) || (r_state == ST_RINSE)) && !w_frozen;
  assign spin_on    = (r_state == ST_SPIN) && !w_frozen;
  assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_wash_ctrl_prog.sv
`default_nettype none
// ============================================================================
// Module : tb_wash_ctrl_prog
// Brief  : Self-checking bench for wash_ctrl_prog with small test timings.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wash_ctrl_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_in = 1'b0;
  logic [1:0] prog = 2'b00;
  logic       door_open = 1'b0;
  logic       timer_pause = 1'b0;
  logic       wash_done, done_pulse, valve_on, agitate_on, spin_on;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] prg;
    int door_at;
    int door_len;
    int pause_at;
    int pause_len;
    int pause_frz;
    int coin_at;
    int exp_len;
    int exp_valve;
    int exp_agit;
    int exp_spin;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];

  wash_ctrl_prog #(
    .CLK_HZ (4), .FILL_S (2), .WASH_S (4), .RINSE_S (3), .SPIN_S (2), .TMR_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .prog        (prog),
    .door_open   (door_open),
    .timer_pause (timer_pause),
    .wash_done   (wash_done),
    .done_pulse  (done_pulse),
    .valve_on    (valve_on),
    .agitate_on  (agitate_on),
    .spin_on     (spin_on),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] p, input int da, input int dl,
                              input int pa, input int pl, input int pf, input int ca,
                              input int len, input int ev, input int ea, input int es);
    vec_t v;
    v.prg = p; v.door_at = da; v.door_len = dl; v.pause_at = pa; v.pause_len = pl;
    v.pause_frz = pf; v.coin_at = ca; v.exp_len = len; v.exp_valve = ev;
    v.exp_agit = ea; v.exp_spin = es;
    return v;
  endfunction

  // One full cycle: coin, per-cycle stimulus from the record, scoreboard check.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int cyc, nv, na, ns, viol, dp_mid;
    bit fin, in_frz;
    string tag;
    tag = $sformatf("v%0d", idx);
    cyc = 0; nv = 0; na = 0; ns = 0; viol = 0; dp_mid = 0; fin = 0;
    @(posedge clk); #1;
    prog = v.prg; coin_in = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    coin_in = 1'b0;
    prog = v.prg ^ 2'b01;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      if (wash_done) begin
        fin = 1;
      end else begin
        cyc++;
        if (cyc == 1) chk({tag, "_latency_valve"}, int'(valve_on), 1);
        nv += int'(valve_on);
        na += int'(agitate_on);
        ns += int'(spin_on);
        if (done_pulse) dp_mid++;
        in_frz = (v.door_len > 0 && cyc >= v.door_at + 2 && cyc <= v.door_at + v.door_len + 1) ||
                 (v.pause_frz != 0 && cyc >= v.pause_at + 2 && cyc <= v.pause_at + v.pause_len + 1);
        if (in_frz && (valve_on || agitate_on || spin_on)) viol++;
        @(posedge clk); #1;
        door_open   = (v.door_len > 0 && cyc >= v.door_at && cyc < v.door_at + v.door_len);
        timer_pause = (v.pause_len > 0 && cyc >= v.pause_at && cyc < v.pause_at + v.pause_len);
        coin_in     = (v.coin_at > 0 && cyc == v.coin_at);
      end
    end
    door_open = 1'b0; timer_pause = 1'b0; coin_in = 1'b0;
    chk({tag, "_timeout"}, int'(fin), 1);
    e = sb_q.pop_front();
    chk({tag, "_low_cycles"}, cyc, e.exp_len);
    chk({tag, "_valve_cycles"}, nv, e.exp_valve);
    chk({tag, "_agit_cycles"}, na, e.exp_agit);
    chk({tag, "_spin_cycles"}, ns, e.exp_spin);
    chk({tag, "_freeze_act"}, viol, 0);
    chk({tag, "_early_pulse"}, dp_mid, 0);
    chk({tag, "_done_pulse"}, int'(done_pulse), 1);
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, int'(done_pulse), 0);
    chk({tag, "_stays_idle"}, int'(state_o), 0);
  endtask

  initial begin
    vecs[0] = mk(2'b00,  0, 0,  0,  0, 0,  0, 44,  8, 28, 8);
    vecs[1] = mk(2'b01,  0, 0,  0,  0, 0,  0, 80, 16, 56, 8);
    vecs[2] = mk(2'b10,  0, 0,  0,  0, 0,  0, 36,  8, 20, 8);
    vecs[3] = mk(2'b11,  0, 0,  0,  0, 0,  0, 56,  8, 40, 8);
    vecs[4] = mk(2'b00,  0, 0, 38, 10, 1,  0, 54,  8, 28, 8);
    vecs[5] = mk(2'b00,  0, 0, 12,  8, 0,  0, 44,  8, 28, 8);
    vecs[6] = mk(2'b00, 12, 8,  0,  0, 0,  0, 52,  8, 28, 8);
    vecs[7] = mk(2'b00,  0, 0,  0,  0, 0, 20, 44,  8, 28, 8);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wash_done", int'(wash_done), 1);
    chk("rst_done_pulse", int'(done_pulse), 0);
    chk("rst_valve", int'(valve_on), 0);
    chk("rst_agitate", int'(agitate_on), 0);
    chk("rst_spin", int'(spin_on), 0);
    chk("rst_state", int'(state_o), 0);

    // Coin while the door is open in IDLE is ignored
    @(posedge clk); #1;
    door_open = 1'b1; coin_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("door_coin_idle", int'(wash_done), 1);
    end
    @(posedge clk); #1;
    coin_in = 1'b0; door_open = 1'b0;
    @(negedge clk);
    chk("door_coin_state", int'(state_o), 0);

    // Table-driven programs, pauses, door freeze and stray coins
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset in the middle of RINSE
    @(posedge clk); #1;
    prog = 2'b00; coin_in = 1'b1;
    @(posedge clk); #1;
    coin_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_state_rinse", int'(state_o), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wash_done", int'(wash_done), 1);
    chk("rst_mid_state", int'(state_o), 0);
    chk("rst_mid_no_pulse", int'(done_pulse), 0);
    chk("rst_mid_agitate", int'(agitate_on), 0);

    // A fresh coin after the abort runs a full cycle
    run_vec(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
